// File: rtl/rst_seq_gen.sv
// rst_seq_gen: reset sequencer for PLL-derived clock domains.
// Synchronises the PLL lock and qualifies it through a lock filter.
// It then releases N_RST active-high resets, bit 0 first, HOLD_CYCLES apart.
// Optional feature macro: RST_SEQ_LOSS_CNT_EN adds the o_loss_cnt lock-loss event counter.
module rst_seq_gen #(
  parameter int N_RST       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int LOSS_CNT_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pll_locked,
  input  logic                  i_rst_req,
  output logic [N_RST-1:0]      o_rst,
  output logic                  o_ready,
`ifdef RST_SEQ_LOSS_CNT_EN
  output logic [LOSS_CNT_W-1:0] o_loss_cnt,
`endif
  output logic [1:0]            o_state
);

  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int IDX_W  = $clog2(N_RST + 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2,
    ST_ILLEGAL   = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lock_s;
  logic                   qual_s;

  state_e                 state_r,  state_nx_s;
  logic [FILT_W-1:0]      filt_r,   filt_nx_s;
  logic [HOLD_W-1:0]      hold_r,   hold_nx_s;
  logic [IDX_W-1:0]       idx_r,    idx_nx_s;
  logic [N_RST-1:0]       rst_r,    rst_nx_s;
  logic                   ready_r,  ready_nx_s;

  assign lock_s = sync_r[SYNC_STAGES-1];
  assign qual_s = lock_s & ~i_rst_req;

  // Bring the asynchronous PLL lock into the i_clk domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], i_pll_locked};
    end
  end

  // Next-state logic; an abort (lock lost or reset request) outranks any scheduled release.
  always_comb begin
    state_nx_s = state_r;
    filt_nx_s  = filt_r;
    hold_nx_s  = hold_r;
    idx_nx_s   = idx_r;
    rst_nx_s   = rst_r;
    ready_nx_s = ready_r;
    case (state_r)
      ST_WAIT_LOCK: begin
        rst_nx_s   = {N_RST{1'b1}};
        ready_nx_s = 1'b0;
        hold_nx_s  = {HOLD_W{1'b0}};
        idx_nx_s   = {IDX_W{1'b0}};
        if (!qual_s) begin
          filt_nx_s = {FILT_W{1'b0}};
        end else if (filt_r == FILT_W'(LOCK_FILTER - 1)) begin
          filt_nx_s  = {FILT_W{1'b0}};
          state_nx_s = ST_RELEASE;
        end else begin
          filt_nx_s = filt_r + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!qual_s) begin
          state_nx_s = ST_WAIT_LOCK;
          filt_nx_s  = {FILT_W{1'b0}};
          hold_nx_s  = {HOLD_W{1'b0}};
          idx_nx_s   = {IDX_W{1'b0}};
          rst_nx_s   = {N_RST{1'b1}};
          ready_nx_s = 1'b0;
        end else if (hold_r == HOLD_W'(HOLD_CYCLES - 1)) begin
          hold_nx_s = {HOLD_W{1'b0}};
          for (int k = 0; k < N_RST; k++) begin
            if (idx_r == IDX_W'(k)) begin
              rst_nx_s[k] = 1'b0;
            end else begin
              rst_nx_s[k] = rst_r[k];
            end
          end
          if (idx_r == IDX_W'(N_RST - 1)) begin
            state_nx_s = ST_RUN;
            ready_nx_s = 1'b1;
          end else begin
            idx_nx_s = idx_r + 1'b1;
          end
        end else begin
          hold_nx_s = hold_r + 1'b1;
        end
      end
      ST_RUN: begin
        if (!qual_s) begin
          state_nx_s = ST_WAIT_LOCK;
          filt_nx_s  = {FILT_W{1'b0}};
          hold_nx_s  = {HOLD_W{1'b0}};
          idx_nx_s   = {IDX_W{1'b0}};
          rst_nx_s   = {N_RST{1'b1}};
          ready_nx_s = 1'b0;
        end else begin
          rst_nx_s   = {N_RST{1'b0}};
          ready_nx_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = ST_WAIT_LOCK;
        filt_nx_s  = {FILT_W{1'b0}};
        hold_nx_s  = {HOLD_W{1'b0}};
        idx_nx_s   = {IDX_W{1'b0}};
        rst_nx_s   = {N_RST{1'b1}};
        ready_nx_s = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs; resets are held asserted while i_rst_n is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_WAIT_LOCK;
      filt_r  <= {FILT_W{1'b0}};
      hold_r  <= {HOLD_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      rst_r   <= {N_RST{1'b1}};
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      filt_r  <= filt_nx_s;
      hold_r  <= hold_nx_s;
      idx_r   <= idx_nx_s;
      rst_r   <= rst_nx_s;
      ready_r <= ready_nx_s;
    end
  end

  assign o_rst   = rst_r;
  assign o_ready = ready_r;
  assign o_state = state_r;

`ifdef RST_SEQ_LOSS_CNT_EN
  logic                  lock_prev_r;
  logic [LOSS_CNT_W-1:0] loss_cnt_r;

  // Count synchronised lock falls seen while releasing or running; saturates, cleared only by i_rst_n.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_prev_r <= 1'b0;
      loss_cnt_r  <= {LOSS_CNT_W{1'b0}};
    end else begin
      lock_prev_r <= lock_s;
      if (lock_prev_r && !lock_s &&
          ((state_r == ST_RELEASE) || (state_r == ST_RUN)) &&
          (loss_cnt_r != {LOSS_CNT_W{1'b1}})) begin
        loss_cnt_r <= loss_cnt_r + 1'b1;
      end
    end
  end

  assign o_loss_cnt = loss_cnt_r;
`endif

endmodule
